// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared control-word, encoding and opcode definitions for the pipeline control path
package pipe_ctrl_pkg;

  // Decoded per-instruction control bundle; all-zero is a bubble.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  // ALU operand source selects
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Next-PC source selects
  localparam logic [1:0] PCSEL_SEQ    = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;
  localparam logic [1:0] PCSEL_JUMP   = 2'b10;

  // ALUOp classes shared with the decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Primary opcodes shared with the decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Hazard controller status
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } hz_state_t;

  // Destination register selected by reg_dst
  function automatic logic [4:0] dest_reg(input logic reg_dst, input logic [4:0] rt,
                                          input logic [4:0] rd);
    return reg_dst ? rd : rt;
  endfunction

  // A used source matches a producer; register 0 never matches
  function automatic logic src_hit(input logic used, input logic [4:0] src,
                                   input logic [4:0] dst);
    return used && (dst != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// rtl/pipe_fwd_unit.sv - combinational ALU operand forward select (used when FORWARDING_EN is defined)
module pipe_fwd_unit (
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_wreg,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_wreg,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  import pipe_ctrl_pkg::*;

  // EX/MEM is the younger producer, so it beats MEM/WB on a double match
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (src_hit(mem_reg_write, ex_rs, mem_wreg))     fwd_a = FWD_EXMEM;
    else if (src_hit(wb_reg_write, ex_rs, wb_wreg))  fwd_a = FWD_MEMWB;
    if (src_hit(mem_reg_write, ex_rt, mem_wreg))     fwd_b = FWD_EXMEM;
    else if (src_hit(wb_reg_write, ex_rt, wb_wreg))  fwd_b = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stage control registers, hazard detect, redirect and stall counter; FORWARDING_EN enables operand forwarding
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_write,
  input  logic             id_mem_read,
  input  logic             id_branch,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_jump,
  input  logic [1:0]       id_alu_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       pc_sel,
  output logic             ex_alu_src,
  output logic             ex_reg_dst,
  output logic [1:0]       ex_alu_op,
  output logic             ex_branch,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_reg_write,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [4:0]       ex_wreg,
  output logic [4:0]       mem_wreg,
  output logic [4:0]       wb_wreg,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);
  import pipe_ctrl_pkg::*;

  ctrl_word_t       id_ctrl;
  ctrl_word_t       ex_ctrl_d;
  ctrl_word_t       ex_ctrl_q;
  ctrl_word_t       mem_ctrl_q;
  ctrl_word_t       wb_ctrl_q;
  logic [4:0]       ex_wreg_d;
  logic [4:0]       ex_rs_d;
  logic [4:0]       ex_rt_d;
  logic [4:0]       ex_rs_q;
  logic [4:0]       ex_rt_q;
  logic [4:0]       ex_wreg_q;
  logic [4:0]       mem_wreg_q;
  logic [4:0]       wb_wreg_q;
  logic [CNT_W-1:0] stall_cnt_q;
  hz_state_t        state_q;
  hz_state_t        state_d;
  logic             uses_rs;
  logic             uses_rt;
  logic             load_use;
  logic             raw_stall;
  logic             stall;
  logic             br_taken;
  logic             inject;

  // Gather the loose ID control inputs into one control word
  always_comb begin
    id_ctrl            = CTRL_BUBBLE;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.branch     = id_branch;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.reg_dst    = id_reg_dst;
    id_ctrl.jump       = id_jump;
    id_ctrl.alu_op     = id_alu_op;
  end

  // Which register fields the ID instruction actually reads
  assign uses_rs = (|id_ctrl) & ~id_jump;
  assign uses_rt = id_reg_dst | id_mem_write | id_branch;

  // A load in EX cannot forward its data to the instruction right behind it
  assign load_use = ex_ctrl_q.mem_read &
                    (src_hit(uses_rs, id_rs, ex_wreg_q) | src_hit(uses_rt, id_rt, ex_wreg_q));

`ifdef FORWARDING_EN
  assign raw_stall = 1'b0;

  pipe_fwd_unit u_fwd (
    .ex_rs         (ex_rs_q),
    .ex_rt         (ex_rt_q),
    .mem_reg_write (mem_ctrl_q.reg_write),
    .mem_wreg      (mem_wreg_q),
    .wb_reg_write  (wb_ctrl_q.reg_write),
    .wb_wreg       (wb_wreg_q),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );
`else
  // Without forwarding, wait until the producer reaches WB (write-first regfile)
  assign raw_stall =
      (ex_ctrl_q.reg_write &
       (src_hit(uses_rs, id_rs, ex_wreg_q) | src_hit(uses_rt, id_rt, ex_wreg_q))) |
      (mem_ctrl_q.reg_write &
       (src_hit(uses_rs, id_rs, mem_wreg_q) | src_hit(uses_rt, id_rt, mem_wreg_q)));

  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;

  wire unused_ops = ^{ex_rs_q, ex_rt_q};
`endif

  assign stall    = load_use | raw_stall;
  assign br_taken = ex_ctrl_q.branch & ex_branch_taken;

  // Redirect/stall arbitration: taken branch beats stall, stall beats jump
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pc_sel     = PCSEL_SEQ;
    inject     = 1'b0;
    if (br_taken) begin
      pc_sel     = PCSEL_BRANCH;
      ifid_flush = 1'b1;
      inject     = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      inject     = 1'b1;
    end else if (id_jump) begin
      pc_sel     = PCSEL_JUMP;
      ifid_flush = 1'b1;
    end
  end

  // Next ID/EX contents: the ID instruction, or a full bubble when squashed/stalled
  always_comb begin
    ex_ctrl_d = id_ctrl;
    ex_wreg_d = dest_reg(id_reg_dst, id_rt, id_rd);
    ex_rs_d   = id_rs;
    ex_rt_d   = id_rt;
    if (inject) begin
      ex_ctrl_d = CTRL_BUBBLE;
      ex_wreg_d = 5'd0;
      ex_rs_d   = 5'd0;
      ex_rt_d   = 5'd0;
    end
  end

  // Stage control registers advance every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q  <= CTRL_BUBBLE;
      mem_ctrl_q <= CTRL_BUBBLE;
      wb_ctrl_q  <= CTRL_BUBBLE;
      ex_wreg_q  <= 5'd0;
      mem_wreg_q <= 5'd0;
      wb_wreg_q  <= 5'd0;
      ex_rs_q    <= 5'd0;
      ex_rt_q    <= 5'd0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_wreg_q  <= ex_wreg_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      mem_ctrl_q <= ex_ctrl_q;
      mem_wreg_q <= ex_wreg_q;
      wb_ctrl_q  <= mem_ctrl_q;
      wb_wreg_q  <= mem_wreg_q;
    end
  end

  // Saturating count of bubbles injected into ID/EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (inject && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Status state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Status next state; it does not feed back into the hazard decisions
  always_comb begin
    state_d = ST_RUN;
    if (br_taken)                          state_d = ST_FLUSH;
    else if (stall && (state_q == ST_RUN)) state_d = ST_LDSTALL;
  end

  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_reg_dst    = ex_ctrl_q.reg_dst;
  assign ex_alu_op     = ex_ctrl_q.alu_op;
  assign ex_branch     = ex_ctrl_q.branch;
  assign mem_mem_read  = mem_ctrl_q.mem_read;
  assign mem_mem_write = mem_ctrl_q.mem_write;
  assign mem_reg_write = mem_ctrl_q.reg_write;
  assign wb_reg_write  = wb_ctrl_q.reg_write;
  assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
  assign ex_wreg       = ex_wreg_q;
  assign mem_wreg      = mem_wreg_q;
  assign wb_wreg       = wb_wreg_q;
  assign stall_cnt     = stall_cnt_q;

  wire unused_wb = ^{wb_ctrl_q.mem_write, wb_ctrl_q.mem_read, wb_ctrl_q.branch,
                     wb_ctrl_q.alu_src, wb_ctrl_q.reg_dst, wb_ctrl_q.jump, wb_ctrl_q.alu_op};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl (expectations follow FORWARDING_EN)
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [9:0] c;  // {rw, m2r, mw, mr, br, as, rdst, j, aluop[1:0]}
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ins_t;

  typedef struct packed {
    int          id;
    logic [4:0]  hz;
    logic [3:0]  fwd;
    logic [14:0] wreg;
    logic [5:0]  wr;
    logic [15:0] cnt;
    logic [1:0]  st;
  } exp_t;

  localparam int HN = 'b11000;  // {pc_write, ifid_write, ifid_flush, pc_sel}
  localparam int HS = 'b00000;
  localparam int HB = 'b11101;
  localparam int HJ = 'b11110;
  localparam int S_RUN = 0;
  localparam int S_LD  = 1;
  localparam int S_FL  = 2;

  logic        clk;
  logic        rst_n;
  logic        taken;
  ins_t        cur;
  logic        pc_write, ifid_write, ifid_flush;
  logic [1:0]  pc_sel;
  logic        ex_alu_src, ex_reg_dst, ex_branch;
  logic [1:0]  ex_alu_op;
  logic        mem_mem_read, mem_mem_write, mem_reg_write;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [4:0]  ex_wreg, mem_wreg, wb_wreg;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  exp_t exp_q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   stepno = 0;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_reg_write    (cur.c[9]),
    .id_mem_to_reg   (cur.c[8]),
    .id_mem_write    (cur.c[7]),
    .id_mem_read     (cur.c[6]),
    .id_branch       (cur.c[5]),
    .id_alu_src      (cur.c[4]),
    .id_reg_dst      (cur.c[3]),
    .id_jump         (cur.c[2]),
    .id_alu_op       (cur.c[1:0]),
    .id_rs           (cur.rs),
    .id_rt           (cur.rt),
    .id_rd           (cur.rd),
    .ex_branch_taken (taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .pc_sel          (pc_sel),
    .ex_alu_src      (ex_alu_src),
    .ex_reg_dst      (ex_reg_dst),
    .ex_alu_op       (ex_alu_op),
    .ex_branch       (ex_branch),
    .mem_mem_read    (mem_mem_read),
    .mem_mem_write   (mem_mem_write),
    .mem_reg_write   (mem_reg_write),
    .wb_reg_write    (wb_reg_write),
    .wb_mem_to_reg   (wb_mem_to_reg),
    .ex_wreg         (ex_wreg),
    .mem_wreg        (mem_wreg),
    .wb_wreg         (wb_wreg),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input logic [9:0] c, input int rs, input int rt, input int rd);
    ins_t i;
    i.c  = c;
    i.rs = 5'(rs);
    i.rt = 5'(rt);
    i.rd = 5'(rd);
    return i;
  endfunction

  function automatic ins_t i_nop();              return mk(10'b0000000000, 0, 0, 0);   endfunction
  function automatic ins_t i_lw(input int rt, input int rs);  return mk(10'b1101010000, rs, rt, 0); endfunction
  function automatic ins_t i_sw(input int rt, input int rs);  return mk(10'b0010010000, rs, rt, 0); endfunction
  function automatic ins_t i_add(input int rd, input int rs, input int rt);
    return mk(10'b1000001010, rs, rt, rd);
  endfunction
  function automatic ins_t i_beq(input int rs, input int rt); return mk(10'b0000100001, rs, rt, 0); endfunction
  function automatic ins_t i_j();                return mk(10'b0000000100, 0, 0, 0);   endfunction
  // Synthetic word that is both a load and a branch, to collide load-use with a taken branch
  function automatic ins_t i_ldbr(input int rt, input int rs); return mk(10'b1001100000, rs, rt, 0); endfunction

  task automatic push_exp(input int hz, input int fw, input int we, input int wm, input int ww,
                          input int wr, input int cnt, input int st);
    exp_t e;
    e.id   = stepno;
    e.hz   = 5'(hz);
    e.fwd  = 4'(fw);
    e.wreg = {5'(we), 5'(wm), 5'(ww)};
    e.wr   = 6'(wr);
    e.cnt  = 16'(cnt);
    e.st   = 2'(st);
    exp_q.push_back(e);
    stepno++;
  endtask

  task automatic step(input ins_t ins, input int tk, input int hz, input int fw, input int we,
                      input int wm, input int ww, input int wr, input int cnt, input int st);
    @(posedge clk);
    #1;
    cur   = ins;
    taken = (tk != 0);
    push_exp(hz, fw, we, wm, ww, wr, cnt, st);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cur   = i_nop();
    taken = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_exp(HN, 0, 0, 0, 0, 0, 0, S_RUN);
  endtask

  // Scoreboard: compare every cycle that has a pending expectation
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      chk($sformatf("hz[%0d]", me.id), 32'({pc_write, ifid_write, ifid_flush, pc_sel}), 32'(me.hz));
      chk($sformatf("fwd[%0d]", me.id), 32'({fwd_a, fwd_b}), 32'(me.fwd));
      chk($sformatf("wreg[%0d]", me.id), 32'({ex_wreg, mem_wreg, wb_wreg}), 32'(me.wreg));
      chk($sformatf("ctl[%0d]", me.id),
          32'({ex_branch, mem_mem_read, mem_mem_write, mem_reg_write, wb_reg_write, wb_mem_to_reg}),
          32'(me.wr));
      chk($sformatf("cnt[%0d]", me.id), 32'(stall_cnt), 32'(me.cnt));
      chk($sformatf("state[%0d]", me.id), 32'(dut.state_q), 32'(me.st));
    end
  end

  initial begin
    rst_n = 1'b0;
    cur   = i_nop();
    taken = 1'b0;

    // load-use: lw $2,0($1); add $3,$2,$4
    do_reset();
`ifdef FORWARDING_EN
    step(i_lw(2, 1),     0, HN, 0,     0, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 2, 4), 0, HS, 0,     2, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 2, 4), 0, HN, 0,     0, 2, 0, 'b010100, 1, S_LD);
    step(i_nop(),        0, HN, 'b0100, 3, 0, 2, 'b000011, 1, S_RUN);
    step(i_nop(),        0, HN, 0,     0, 3, 0, 'b000100, 1, S_RUN);
`else
    step(i_lw(2, 1),     0, HN, 0, 0, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 2, 4), 0, HS, 0, 2, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 2, 4), 0, HS, 0, 0, 2, 0, 'b010100, 1, S_LD);
    step(i_add(3, 2, 4), 0, HN, 0, 0, 0, 2, 'b000011, 2, S_RUN);
    step(i_nop(),        0, HN, 0, 3, 0, 0, 'b000000, 2, S_RUN);
    step(i_nop(),        0, HN, 0, 0, 3, 0, 'b000100, 2, S_RUN);
`endif

    // ALU RAW: add $2,$1,$1; sub $3,$2,$2
    do_reset();
`ifdef FORWARDING_EN
    step(i_add(2, 1, 1), 0, HN, 0,      0, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 2, 2), 0, HN, 0,      2, 0, 0, 'b000000, 0, S_RUN);
    step(i_nop(),        0, HN, 'b1010, 3, 2, 0, 'b000100, 0, S_RUN);
    step(i_nop(),        0, HN, 0,      0, 3, 2, 'b000110, 0, S_RUN);
`else
    step(i_add(2, 1, 1), 0, HN, 0, 0, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 2, 2), 0, HS, 0, 2, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 2, 2), 0, HS, 0, 0, 2, 0, 'b000100, 1, S_LD);
    step(i_add(3, 2, 2), 0, HN, 0, 0, 0, 2, 'b000010, 2, S_RUN);
    step(i_nop(),        0, HN, 0, 3, 0, 0, 'b000000, 2, S_RUN);
    step(i_nop(),        0, HN, 0, 0, 3, 0, 'b000100, 2, S_RUN);
`endif

    // taken beq: wrong-path sw squashed in ID, IF slot flushed to nop
    do_reset();
    step(i_beq(1, 1),    0, HN, 0, 0, 0, 0, 'b000000, 0, S_RUN);
    step(i_sw(5, 6),     1, HB, 0, 1, 0, 0, 'b100000, 0, S_RUN);
    step(i_nop(),        0, HN, 0, 0, 1, 0, 'b000000, 1, S_FL);
    step(i_add(8, 1, 1), 0, HN, 0, 0, 0, 1, 'b000000, 1, S_RUN);
    step(i_nop(),        0, HN, 0, 8, 0, 0, 'b000000, 1, S_RUN);
    step(i_nop(),        0, HN, 0, 0, 8, 0, 'b000100, 1, S_RUN);

    // load-use and taken branch in the same cycle: flush wins
    do_reset();
    step(i_ldbr(2, 1),   0, HN, 0, 0, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 2, 4), 1, HB, 0, 2, 0, 0, 'b100000, 0, S_RUN);
    step(i_nop(),        0, HN, 0, 0, 2, 0, 'b010100, 1, S_FL);
    step(i_nop(),        0, HN, 0, 0, 0, 2, 'b000010, 1, S_RUN);

    // register 0 never hazards or forwards
    do_reset();
    step(i_lw(0, 1),     0, HN, 0, 0, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 0, 4), 0, HN, 0, 0, 0, 0, 'b000000, 0, S_RUN);
    step(i_nop(),        0, HN, 0, 3, 0, 0, 'b010100, 0, S_RUN);

    // jump redirect, then async reset in the middle of a load-use stall
    do_reset();
    step(i_j(),          0, HJ, 0, 0, 0, 0, 'b000000, 0, S_RUN);
    step(i_nop(),        0, HN, 0, 0, 0, 0, 'b000000, 0, S_RUN);
    step(i_lw(2, 1),     0, HN, 0, 0, 0, 0, 'b000000, 0, S_RUN);
    step(i_add(3, 2, 4), 0, HS, 0, 2, 0, 0, 'b000000, 0, S_RUN);
    @(posedge clk);
    #1;
    cur = i_add(3, 2, 4);
    chk("pre_rst_cnt", 32'(stall_cnt), 32'd1);
    chk("pre_rst_state", 32'(dut.state_q), 32'(S_LD));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_hz", 32'({pc_write, ifid_write, ifid_flush, pc_sel}), 32'(HN));
    chk("arst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("arst_wreg", 32'({ex_wreg, mem_wreg, wb_wreg}), 32'd0);
    chk("arst_ctl", 32'({ex_alu_src, ex_reg_dst, ex_alu_op, ex_branch, mem_mem_read,
                         mem_mem_write, mem_reg_write, wb_reg_write, wb_mem_to_reg}), 32'd0);
    chk("arst_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(S_RUN));
    do_reset();

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
